// File: rtl/rect_fill_engine.sv
// Rectangle draw accelerator: latches two corners and a colour, then emits one
// VRAM write per cycle in raster order (filled or 1-pixel outline), clipped to VRAM.
// Ports: Clock/Reset (async active-low); iStart + iX0/iY0/iX1/iY1/iColor/iOutline
// command; iWrReady back-pressure; oWrEnable/oWrAddress/oWrColor write port;
// oBusy during SETUP/RUN; oDone one-cycle completion pulse.
module rect_fill_engine #(
    parameter int VRAM_W  = 80,
    parameter int VRAM_H  = 60,
    parameter int COORD_W = 16,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iX0,
    input  logic [COORD_W-1:0] iY0,
    input  logic [COORD_W-1:0] iX1,
    input  logic [COORD_W-1:0] iY1,
    input  logic [COLOR_W-1:0] iColor,
    input  logic               iOutline,
    input  logic               iWrReady,
    output logic               oWrEnable,
    output logic [ADDR_W-1:0]  oWrAddress,
    output logic [COLOR_W-1:0] oWrColor,
    output logic               oBusy,
    output logic               oDone
);

    localparam int CW1 = COORD_W + 1;
    localparam logic [CW1-1:0] XLIM = CW1'(VRAM_W - 1);
    localparam logic [CW1-1:0] YLIM = CW1'(VRAM_H - 1);

    typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0] ax, ay, bx, by;
    logic [COLOR_W-1:0] color_q;
    logic               outline_q;
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
    logic [COORD_W-1:0] x, y, x_nxt, y_nxt;

    // Corner ordering and clipping, one bit wider so nothing wraps.
    logic [CW1-1:0] ax_e, ay_e, bx_e, by_e;
    logic [CW1-1:0] lo_x, hi_x, lo_y, hi_y, hi_xc, hi_yc;
    logic           empty;

    assign ax_e  = {1'b0, ax};
    assign ay_e  = {1'b0, ay};
    assign bx_e  = {1'b0, bx};
    assign by_e  = {1'b0, by};
    assign lo_x  = (ax_e < bx_e) ? ax_e : bx_e;
    assign hi_x  = (ax_e < bx_e) ? bx_e : ax_e;
    assign lo_y  = (ay_e < by_e) ? ay_e : by_e;
    assign hi_y  = (ay_e < by_e) ? by_e : ay_e;
    assign hi_xc = (hi_x > XLIM) ? XLIM : hi_x;
    assign hi_yc = (hi_y > YLIM) ? YLIM : hi_y;
    assign empty = (lo_x > XLIM) || (lo_y > YLIM);

    logic last_col, last_row, inner_row;

    assign last_col  = (x == xmax);
    assign last_row  = (y == ymax);
    // Interior rows of an outline only touch their two edge pixels.
    assign inner_row = outline_q && (y != ymin) && (y != ymax);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        unique case (state)
            IDLE: begin
                if (iStart) state_nxt = SETUP;
            end
            SETUP: begin
                x_nxt     = lo_x[COORD_W-1:0];
                y_nxt     = lo_y[COORD_W-1:0];
                state_nxt = empty ? DONE : RUN;
            end
            RUN: begin
                if (iWrReady) begin
                    if (last_col) begin
                        if (last_row) begin
                            state_nxt = DONE;
                        end else begin
                            x_nxt = xmin;
                            y_nxt = y + COORD_W'(1);
                        end
                    end else if (inner_row && x == xmin) begin
                        x_nxt = xmax;
                    end else begin
                        x_nxt = x + COORD_W'(1);
                    end
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ax        <= '0;
            ay        <= '0;
            bx        <= '0;
            by        <= '0;
            color_q   <= '0;
            outline_q <= 1'b0;
            xmin      <= '0;
            xmax      <= '0;
            ymin      <= '0;
            ymax      <= '0;
            x         <= '0;
            y         <= '0;
        end else begin
            if (state == IDLE && iStart) begin
                ax        <= iX0;
                ay        <= iY0;
                bx        <= iX1;
                by        <= iY1;
                color_q   <= iColor;
                outline_q <= iOutline;
            end
            if (state == SETUP) begin
                xmin <= lo_x[COORD_W-1:0];
                xmax <= hi_xc[COORD_W-1:0];
                ymin <= lo_y[COORD_W-1:0];
                ymax <= hi_yc[COORD_W-1:0];
            end
            x <= x_nxt;
            y <= y_nxt;
        end
    end

    logic [ADDR_W-1:0] row_base;

    assign row_base   = ADDR_W'(y) * ADDR_W'(VRAM_W);
    assign oWrEnable  = (state == RUN);
    assign oWrAddress = (state == RUN) ? row_base + ADDR_W'(x) : '0;
    assign oWrColor   = (state == RUN) ? color_q : '0;
    assign oBusy      = (state == SETUP) || (state == RUN);
    assign oDone      = (state == DONE);

endmodule

// File: tb/tb_rect_fill_engine.sv
// Scoreboard bench for rect_fill_engine: directed commands push expected writes,
// a monitor pops and compares every presented write.
module tb_rect_fill_engine;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic [15:0] iX0, iY0, iX1, iY1;
    logic [2:0]  iColor;
    logic        iOutline;
    logic        iWrReady;
    logic        oWrEnable;
    logic [15:0] oWrAddress;
    logic [2:0]  oWrColor;
    logic        oBusy;
    logic        oDone;

    rect_fill_engine dut (
        .Clock(Clock), .Reset(Reset), .iStart(iStart),
        .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1),
        .iColor(iColor), .iOutline(iOutline), .iWrReady(iWrReady),
        .oWrEnable(oWrEnable), .oWrAddress(oWrAddress),
        .oWrColor(oWrColor), .oBusy(oBusy), .oDone(oDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    int exp_a[$];
    int exp_c[$];
    int stall_addr = -1;
    int stall_left = 0;

    int t1[6]  = '{242, 243, 244, 322, 323, 324};
    int t2b[4] = '{4718, 4719, 4798, 4799};
    int t3[10] = '{0, 1, 2, 3, 80, 83, 160, 161, 162, 163};
    int t7[4]  = '{565, 566, 567, 568};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int a, input int c);
        exp_a.push_back(a);
        exp_c.push_back(c);
    endtask

    // Back-pressure source: drops ready for stall_left cycles at stall_addr.
    initial begin
        iWrReady = 1'b1;
        forever begin
            @(negedge Clock);
            if (stall_left > 0 && oWrEnable && int'(oWrAddress) == stall_addr) begin
                iWrReady = 1'b0;
                stall_left--;
            end else begin
                iWrReady = 1'b1;
            end
        end
    end

    // Monitor: every presented write must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge Clock);
            #2;
            if (Reset && oWrEnable) begin
                checks++;
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d color=%0d",
                             oWrAddress, oWrColor);
                end else begin
                    if (int'(oWrAddress) != exp_a[0] || int'(oWrColor) != exp_c[0]) begin
                        errors++;
                        $display("FAIL write addr=%0d color=%0d expected addr=%0d color=%0d",
                                 oWrAddress, oWrColor, exp_a[0], exp_c[0]);
                    end
                    if (iWrReady) begin
                        void'(exp_a.pop_front());
                        void'(exp_c.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input int x0, input int y0, input int x1, input int y1,
                         input int col, input bit outl);
        @(posedge Clock);
        #1;
        iX0      = 16'(x0);
        iY0      = 16'(y0);
        iX1      = 16'(x1);
        iY1      = 16'(y1);
        iColor   = 3'(col);
        iOutline = outl;
        iStart   = 1'b1;
        @(posedge Clock);
        #1;
        iStart   = 1'b0;
        iX0      = 16'($urandom_range(0, 79));
        iY0      = 16'($urandom_range(0, 59));
        iX1      = 16'($urandom_range(0, 79));
        iY1      = 16'($urandom_range(0, 59));
        iColor   = 3'($urandom_range(0, 7));
        iOutline = 1'($urandom_range(0, 1));
    endtask

    // Cycle k=1 is the SETUP cycle after the latching edge.
    task automatic run_cmd(input string name, input int x0, input int y0,
                           input int x1, input int y1, input int col,
                           input bit outl, input int exp_lat, input int poke_k);
        int lat;
        lat = 0;
        issue(x0, y0, x1, y1, col, outl);
        for (int k = 1; k <= 300; k++) begin
            @(negedge Clock);
            if (k == 1) chk({name, "_busy_setup"}, int'(oBusy), 1);
            if (k == poke_k) iStart = 1'b1;
            else iStart = 1'b0;
            if (oDone) begin
                lat = k;
                break;
            end
        end
        iStart = 1'b0;
        chk({name, "_done_cycle"}, lat, exp_lat);
        chk({name, "_busy_at_done"}, int'(oBusy), 0);
        chk({name, "_wren_at_done"}, int'(oWrEnable), 0);
        chk({name, "_writes_left"}, exp_a.size(), 0);
    endtask

    initial begin
        int found;
        Reset    = 1'b0;
        iStart   = 1'b0;
        iX0      = '0;
        iY0      = '0;
        iX1      = '0;
        iY1      = '0;
        iColor   = '0;
        iOutline = 1'b0;
        #1;
        chk("reset_wren", int'(oWrEnable), 0);
        chk("reset_addr", int'(oWrAddress), 0);
        chk("reset_busy", int'(oBusy), 0);
        chk("reset_done", int'(oDone), 0);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;

        foreach (t1[i]) push(t1[i], 5);
        run_cmd("t1_fill", 2, 3, 4, 4, 5, 1'b0, 8, 0);

        foreach (t1[i]) push(t1[i], 5);
        run_cmd("t2_swap", 4, 4, 2, 3, 5, 1'b0, 8, 0);

        foreach (t2b[i]) push(t2b[i], 2);
        run_cmd("t2_clip", 78, 58, 100, 70, 2, 1'b0, 6, 0);

        run_cmd("t2_empty", 90, 0, 95, 5, 7, 1'b0, 2, 0);

        foreach (t3[i]) push(t3[i], 6);
        run_cmd("t3_outline", 0, 0, 3, 2, 6, 1'b1, 12, 0);

        foreach (t7[i]) push(t7[i], 1);
        run_cmd("outline_row", 8, 7, 5, 7, 1, 1'b1, 6, 0);

        stall_addr = 243;
        stall_left = 3;
        foreach (t1[i]) push(t1[i], 5);
        run_cmd("t4_stall", 2, 3, 4, 4, 5, 1'b0, 11, 0);
        chk("t4_stall_used", stall_left, 0);
        stall_addr = -1;

        foreach (t1[i]) push(t1[i], 5);
        run_cmd("t5_poke", 2, 3, 4, 4, 5, 1'b0, 8, 4);
        foreach (t2b[i]) push(t2b[i], 3);
        run_cmd("t5_b2b", 78, 58, 100, 70, 3, 1'b0, 6, 0);

        foreach (t1[i]) push(t1[i], 5);
        issue(2, 3, 4, 4, 5, 1'b0);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (oWrEnable && oWrAddress == 16'd322) begin
                found = 1;
                break;
            end
        end
        chk("t6_reach_third", found, 1);
        #3;
        Reset = 1'b0;
        #1;
        chk("t6_rst_wren", int'(oWrEnable), 0);
        chk("t6_rst_addr", int'(oWrAddress), 0);
        chk("t6_rst_color", int'(oWrColor), 0);
        chk("t6_rst_busy", int'(oBusy), 0);
        exp_a.delete();
        exp_c.delete();
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clock);
            chk("t6_idle_wren", int'(oWrEnable), 0);
            chk("t6_idle_busy", int'(oBusy), 0);
        end

        foreach (t1[i]) push(t1[i], 4);
        run_cmd("t6_recover", 2, 3, 4, 4, 4, 1'b0, 8, 0);

        repeat (3) @(posedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

endmodule
